// File: rtl/usb_fs_nb_in_ep_ctrl_pkg.sv
// Shared usbdev definitions for the full-speed IN endpoint controller.
// Holds the PID codes, the token kinds and the default endpoint geometry.
package usb_fs_nb_in_ep_ctrl_pkg;

  localparam int NumInEpsDefault         = 11;
  localparam int MaxInPktSizeByteDefault = 32;

  localparam logic [3:0] UsbPidOut   = 4'b0001;
  localparam logic [3:0] UsbPidIn    = 4'b1001;
  localparam logic [3:0] UsbPidSof   = 4'b0101;
  localparam logic [3:0] UsbPidSetup = 4'b1101;
  localparam logic [3:0] UsbPidData0 = 4'b0011;
  localparam logic [3:0] UsbPidData1 = 4'b1011;
  localparam logic [3:0] UsbPidAck   = 4'b0010;
  localparam logic [3:0] UsbPidNak   = 4'b1010;
  localparam logic [3:0] UsbPidStall = 4'b1110;

  typedef enum logic [1:0] {
    TokOut   = 2'd0,
    TokIn    = 2'd1,
    TokSetup = 2'd2,
    TokSof   = 2'd3
  } usb_token_e;

endpackage

// File: rtl/usb_fs_nb_in_ep_ctrl_cfg_bank.sv
// Per-endpoint IN configuration registers: buffer id, packet size, ready and stall.
// Ready is also cleared by bus reset and by an acknowledged packet.
module usb_fs_nb_in_ep_ctrl_cfg_bank
  import usb_fs_nb_in_ep_ctrl_pkg::*;
#(
  parameter int NumInEps         = NumInEpsDefault,
  parameter int MaxInPktSizeByte = MaxInPktSizeByteDefault,
  parameter int PktW             = $clog2(MaxInPktSizeByte),
  parameter int BufW             = 5,
  parameter int InEpW            = $clog2(NumInEps)
) (
  input  logic                               clk_48mhz,
  input  logic                               rst_n,
  input  logic                               link_reset,
  input  logic                               wr_en,
  input  logic [InEpW-1:0]                   wr_ep,
  input  logic [BufW-1:0]                    wr_buf,
  input  logic [PktW:0]                      wr_size,
  input  logic                               wr_rdy,
  input  logic                               wr_stall,
  input  logic [NumInEps-1:0]                rdy_clr,
  output logic [NumInEps-1:0][BufW-1:0]      bufs,
  output logic [NumInEps-1:0][PktW:0]        sizes,
  output logic [NumInEps-1:0]                rdy,
  output logic [NumInEps-1:0]                stall
);

  localparam logic [PktW:0] MaxSize = (PktW+1)'(MaxInPktSizeByte);

  function automatic logic [PktW:0] clamp_size(input logic [PktW:0] s);
    return (s > MaxSize) ? MaxSize : s;
  endfunction

  logic [NumInEps-1:0] wr_hit;
  logic [NumInEps-1:0] rdy_nxt;

  always_comb begin
    wr_hit  = '0;
    rdy_nxt = rdy & ~rdy_clr;
    for (int e = 0; e < NumInEps; e++) begin
      wr_hit[e] = wr_en && (wr_ep == InEpW'(e));
      if (wr_hit[e]) begin
        rdy_nxt[e] = wr_rdy;
      end
    end
  end

  always_ff @(posedge clk_48mhz or negedge rst_n) begin
    if (!rst_n) begin
      bufs  <= '0;
      sizes <= '0;
      rdy   <= '0;
      stall <= '0;
    end else begin
      for (int e = 0; e < NumInEps; e++) begin
        if (wr_hit[e] && !link_reset) begin
          bufs[e]  <= wr_buf;
          sizes[e] <= clamp_size(wr_size);
          stall[e] <= wr_stall;
        end
      end
      // Bus reset drops every armed packet but keeps the programmed layout.
      rdy <= link_reset ? '0 : rdy_nxt;
    end
  end

endmodule

// File: rtl/usb_fs_nb_in_ep_ctrl.sv
// Full-speed non-blocking IN endpoint controller: tracks in-flight and sent
// packets and presents ready/stall/done and buffer addressing to the engine.
module usb_fs_nb_in_ep_ctrl
  import usb_fs_nb_in_ep_ctrl_pkg::*;
#(
  parameter int NumInEps         = NumInEpsDefault,
  parameter int MaxInPktSizeByte = MaxInPktSizeByteDefault,
  parameter int PktW             = $clog2(MaxInPktSizeByte),
  parameter int BufW             = 5,
  parameter int InEpW            = $clog2(NumInEps)
) (
  input  logic                   clk_48mhz_i,
  input  logic                   rst_ni,
  input  logic                   link_reset_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [3:0]             cfg_ep_i,
  input  logic [BufW-1:0]        cfg_buf_i,
  input  logic [PktW:0]          cfg_size_i,
  input  logic                   cfg_rdy_i,
  input  logic                   cfg_stall_i,
  output logic [NumInEps-1:0]    sent_o,
  input  logic [NumInEps-1:0]    sent_clr_i,
  output logic                   pkt_sent_o,
  input  logic [3:0]             in_ep_current_i,
  input  logic [PktW-1:0]        in_ep_get_addr_i,
  input  logic                   in_ep_data_get_i,
  input  logic                   in_ep_newpkt_i,
  input  logic                   in_ep_acked_i,
  input  logic                   in_ep_rollback_i,
  output logic [NumInEps-1:0]    in_ep_has_data_o,
  output logic [NumInEps-1:0]    in_ep_stall_o,
  output logic [NumInEps-1:0]    in_ep_data_done_o,
  output logic [BufW+PktW-1:0]   buf_raddr_o,
  output logic                   buf_re_o
);

  localparam logic [3:0] EpLimit = 4'(NumInEps);

  logic [NumInEps-1:0][BufW-1:0] bufs;
  logic [NumInEps-1:0][PktW:0]   sizes;
  logic [NumInEps-1:0]           rdy;
  logic [NumInEps-1:0]           stall;
  logic [NumInEps-1:0]           busy;
  logic [NumInEps-1:0]           sent;
  logic                          pkt_sent;

  logic                          cur_valid;
  logic                          cfg_ep_valid;
  logic [NumInEps-1:0]           cur_oh;
  logic [NumInEps-1:0]           ack_oh;
  logic [NumInEps-1:0]           busy_set;
  logic [NumInEps-1:0]           busy_clr;
  logic [NumInEps-1:0]           busy_nxt;
  logic [NumInEps-1:0]           sent_nxt;
  logic                          cfg_wr;

  assign cur_valid    = in_ep_current_i < EpLimit;
  assign cfg_ep_valid = cfg_ep_i < EpLimit;
  assign cur_oh       = cur_valid ? (NumInEps'(1) << in_ep_current_i) : '0;

  // Writes to an endpoint the engine is still sending from must wait.
  assign cfg_ready_o  = !link_reset_i && !(cfg_ep_valid && busy[cfg_ep_i]);
  assign cfg_wr       = cfg_valid_i && cfg_ready_o && cfg_ep_valid;

  assign ack_oh   = in_ep_acked_i ? cur_oh : '0;
  assign busy_set = (in_ep_newpkt_i ? cur_oh : '0) & rdy & ~stall;
  assign busy_clr = (in_ep_acked_i || in_ep_rollback_i) ? cur_oh : '0;
  // A retry token in the rollback cycle re-arms the same packet.
  assign busy_nxt = busy_set | (busy & ~busy_clr);
  assign sent_nxt = (sent & ~sent_clr_i) | ack_oh;

  usb_fs_nb_in_ep_ctrl_cfg_bank #(
    .NumInEps         (NumInEps),
    .MaxInPktSizeByte (MaxInPktSizeByte),
    .PktW             (PktW),
    .BufW             (BufW),
    .InEpW            (InEpW)
  ) u_cfg_bank (
    .clk_48mhz  (clk_48mhz_i),
    .rst_n      (rst_ni),
    .link_reset (link_reset_i),
    .wr_en      (cfg_wr),
    .wr_ep      (cfg_ep_i[InEpW-1:0]),
    .wr_buf     (cfg_buf_i),
    .wr_size    (cfg_size_i),
    .wr_rdy     (cfg_rdy_i),
    .wr_stall   (cfg_stall_i),
    .rdy_clr    (ack_oh),
    .bufs       (bufs),
    .sizes      (sizes),
    .rdy        (rdy),
    .stall      (stall)
  );

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy     <= '0;
      sent     <= '0;
      pkt_sent <= 1'b0;
    end else if (link_reset_i) begin
      busy     <= '0;
      sent     <= '0;
      pkt_sent <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      sent     <= sent_nxt;
      pkt_sent <= in_ep_acked_i && cur_valid;
    end
  end

  always_comb begin
    in_ep_data_done_o = '1;
    if (cur_valid) begin
      in_ep_data_done_o[in_ep_current_i] = ({1'b0, in_ep_get_addr_i} >= sizes[in_ep_current_i]);
    end
  end

  assign buf_raddr_o      = {(cur_valid ? bufs[in_ep_current_i] : {BufW{1'b0}}), in_ep_get_addr_i};
  // Byte 0 is fetched with the token so it is ready when the engine asks.
  assign buf_re_o         = in_ep_data_get_i || in_ep_newpkt_i;
  assign in_ep_has_data_o = rdy;
  assign in_ep_stall_o    = stall;
  assign sent_o           = sent;
  assign pkt_sent_o       = pkt_sent;

endmodule

// File: tb/tb_usb_fs_nb_in_ep_ctrl.sv
// Self-checking bench for usb_fs_nb_in_ep_ctrl: directed scenarios with a
// scoreboard for the packet read-address/done sequence.
module tb_usb_fs_nb_in_ep_ctrl;

  localparam int N = 11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_ep;
  logic [4:0]  cfg_buf;
  logic [5:0]  cfg_size;
  logic        cfg_rdy;
  logic        cfg_stall;
  logic [N-1:0] sent;
  logic [N-1:0] sent_clr;
  logic        pkt_sent;
  logic [3:0]  cur;
  logic [4:0]  addr;
  logic        data_get;
  logic        newpkt;
  logic        acked;
  logic        rollback;
  logic [N-1:0] has_data;
  logic [N-1:0] stall_o;
  logic [N-1:0] done;
  logic [9:0]  raddr;
  logic        buf_re;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [9:0] raddr;
    logic       done;
  } exp_t;
  exp_t sb[$];

  always #10 clk = ~clk;

  usb_fs_nb_in_ep_ctrl dut (
    .clk_48mhz_i       (clk),
    .rst_ni            (rst_n),
    .link_reset_i      (link_reset),
    .cfg_valid_i       (cfg_valid),
    .cfg_ready_o       (cfg_ready),
    .cfg_ep_i          (cfg_ep),
    .cfg_buf_i         (cfg_buf),
    .cfg_size_i        (cfg_size),
    .cfg_rdy_i         (cfg_rdy),
    .cfg_stall_i       (cfg_stall),
    .sent_o            (sent),
    .sent_clr_i        (sent_clr),
    .pkt_sent_o        (pkt_sent),
    .in_ep_current_i   (cur),
    .in_ep_get_addr_i  (addr),
    .in_ep_data_get_i  (data_get),
    .in_ep_newpkt_i    (newpkt),
    .in_ep_acked_i     (acked),
    .in_ep_rollback_i  (rollback),
    .in_ep_has_data_o  (has_data),
    .in_ep_stall_o     (stall_o),
    .in_ep_data_done_o (done),
    .buf_raddr_o       (raddr),
    .buf_re_o          (buf_re)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ep, input int b, input int s, input bit r, input bit st);
    cfg_ep    = 4'(ep);
    cfg_buf   = 5'(b);
    cfg_size  = 6'(s);
    cfg_rdy   = r;
    cfg_stall = st;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total_cnt++; if (has_data !== '0) $display("FAIL reset_has_data got=%b exp=0", has_data); else pass_cnt++;
    total_cnt++; if (stall_o !== '0) $display("FAIL reset_stall got=%b exp=0", stall_o); else pass_cnt++;
    total_cnt++; if (sent !== '0) $display("FAIL reset_sent got=%b exp=0", sent); else pass_cnt++;
    total_cnt++; if (pkt_sent !== 1'b0) $display("FAIL reset_pkt_sent got=%b exp=0", pkt_sent); else pass_cnt++;
    total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); else pass_cnt++;
    total_cnt++; if (done !== '1) $display("FAIL reset_done got=%b exp=all1", done); else pass_cnt++;
  endtask

  task automatic test_config();
    cfg_write(2, 5, 8, 1'b1, 1'b0);
    total_cnt++; if (has_data !== 11'b100) $display("FAIL cfg_has_data got=%b exp=%b", has_data, 11'b100); else pass_cnt++;
    total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL cfg_ready got=%b exp=1", cfg_ready); else pass_cnt++;
  endtask

  task automatic test_packet();
    exp_t e;
    cur = 4'd2; addr = 5'd0; newpkt = 1'b1;
    #1;
    total_cnt++; if (buf_re !== 1'b1) $display("FAIL pkt_prefetch_re got=%b exp=1", buf_re); else pass_cnt++;
    tick();
    newpkt = 1'b0; cfg_ep = 4'd2;
    #1;
    total_cnt++; if (cfg_ready !== 1'b0) $display("FAIL pkt_busy_blocks got=%b exp=0", cfg_ready); else pass_cnt++;
    data_get = 1'b1;
    for (int a = 0; a <= 8; a++) begin
      addr = 5'(a);
      sb.push_back('{raddr: {5'd5, 5'(a)}, done: (a >= 8)});
      #1;
      e = sb.pop_front();
      total_cnt++; if (raddr !== e.raddr) $display("FAIL pkt_raddr a=%0d got=%h exp=%h", a, raddr, e.raddr); else pass_cnt++;
      total_cnt++; if ({done[2], done[10:3], done[1:0]} !== {e.done, 10'h3ff}) $display("FAIL pkt_done a=%0d got=%b exp_bit2=%b", a, done, e.done); else pass_cnt++;
      tick();
    end
    data_get = 1'b0;
    acked = 1'b1;
    tick();
    acked = 1'b0;
    total_cnt++; if (has_data[2] !== 1'b0) $display("FAIL ack_rdy got=%b exp=0", has_data[2]); else pass_cnt++;
    total_cnt++; if (sent !== 11'b100) $display("FAIL ack_sent got=%b exp=%b", sent, 11'b100); else pass_cnt++;
    total_cnt++; if (pkt_sent !== 1'b1) $display("FAIL ack_pulse got=%b exp=1", pkt_sent); else pass_cnt++;
    total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL ack_unbusy got=%b exp=1", cfg_ready); else pass_cnt++;
    sent_clr = 11'b100;
    tick();
    sent_clr = '0;
    total_cnt++; if (pkt_sent !== 1'b0) $display("FAIL ack_pulse_end got=%b exp=0", pkt_sent); else pass_cnt++;
    total_cnt++; if (sent !== '0) $display("FAIL sent_clr got=%b exp=0", sent); else pass_cnt++;
  endtask

  task automatic test_retry();
    cfg_write(2, 6, 4, 1'b1, 1'b0);
    cur = 4'd2; newpkt = 1'b1;
    tick();
    rollback = 1'b1;
    tick();
    newpkt = 1'b0; rollback = 1'b0;
    cfg_ep = 4'd2; cfg_buf = 5'd7; cfg_size = 6'd3; cfg_rdy = 1'b1; cfg_stall = 1'b0;
    cfg_valid = 1'b1; addr = 5'd3;
    #1;
    total_cnt++; if (cfg_ready !== 1'b0) $display("FAIL retry_busy got=%b exp=0", cfg_ready); else pass_cnt++;
    total_cnt++; if (has_data[2] !== 1'b1) $display("FAIL retry_rdy got=%b exp=1", has_data[2]); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (done[2] !== 1'b0) $display("FAIL retry_held_size got=%b exp=0", done[2]); else pass_cnt++;
    total_cnt++; if (raddr !== {5'd6, 5'd3}) $display("FAIL retry_held_buf got=%h exp=%h", raddr, {5'd6, 5'd3}); else pass_cnt++;
    acked = 1'b1;
    tick();
    acked = 1'b0;
    total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL retry_release got=%b exp=1", cfg_ready); else pass_cnt++;
    tick();
    cfg_valid = 1'b0;
    total_cnt++; if (done[2] !== 1'b1) $display("FAIL retry_new_size got=%b exp=1", done[2]); else pass_cnt++;
    total_cnt++; if (raddr !== {5'd7, 5'd3}) $display("FAIL retry_new_buf got=%h exp=%h", raddr, {5'd7, 5'd3}); else pass_cnt++;
    total_cnt++; if (has_data[2] !== 1'b1) $display("FAIL retry_new_rdy got=%b exp=1", has_data[2]); else pass_cnt++;
    total_cnt++; if (sent !== 11'b100) $display("FAIL retry_sent got=%b exp=%b", sent, 11'b100); else pass_cnt++;
    sent_clr = 11'b100;
    tick();
    sent_clr = '0;
  endtask

  task automatic test_zlp();
    cfg_write(1, 3, 0, 1'b1, 1'b0);
    cur = 4'd1; addr = 5'd0; newpkt = 1'b1;
    #1;
    total_cnt++; if (done[1] !== 1'b1) $display("FAIL zlp_done got=%b exp=1", done[1]); else pass_cnt++;
    total_cnt++; if (raddr !== {5'd3, 5'd0}) $display("FAIL zlp_raddr got=%h exp=%h", raddr, {5'd3, 5'd0}); else pass_cnt++;
    tick();
    newpkt = 1'b0;
    acked = 1'b1; sent_clr = 11'b10;
    tick();
    acked = 1'b0; sent_clr = '0;
    total_cnt++; if (sent !== 11'b10) $display("FAIL zlp_set_wins got=%b exp=%b", sent, 11'b10); else pass_cnt++;
    total_cnt++; if (pkt_sent !== 1'b1) $display("FAIL zlp_pulse got=%b exp=1", pkt_sent); else pass_cnt++;
    total_cnt++; if (has_data[1] !== 1'b0) $display("FAIL zlp_rdy got=%b exp=0", has_data[1]); else pass_cnt++;
  endtask

  task automatic test_clamp_stall();
    cfg_write(0, 2, 40, 1'b1, 1'b1);
    total_cnt++; if (stall_o !== 11'b1) $display("FAIL stall_out got=%b exp=%b", stall_o, 11'b1); else pass_cnt++;
    cur = 4'd0; addr = 5'd31;
    #1;
    total_cnt++; if (done !== 11'h7fe) $display("FAIL max_size_done got=%b exp=%b", done, 11'h7fe); else pass_cnt++;
    newpkt = 1'b1;
    tick();
    newpkt = 1'b0; cfg_ep = 4'd0;
    #1;
    total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL stall_no_busy got=%b exp=1", cfg_ready); else pass_cnt++;
    cur = 4'd12;
    #1;
    total_cnt++; if (done !== '1) $display("FAIL bad_ep_done got=%b exp=all1", done); else pass_cnt++;
  endtask

  task automatic test_link_reset();
    cfg_write(3, 9, 16, 1'b1, 1'b0);
    cur = 4'd3; newpkt = 1'b1;
    tick();
    newpkt = 1'b0; cfg_ep = 4'd3;
    #1;
    total_cnt++; if (cfg_ready !== 1'b0) $display("FAIL lr_busy got=%b exp=0", cfg_ready); else pass_cnt++;
    link_reset = 1'b1;
    cfg_ep = 4'd4; cfg_buf = 5'd1; cfg_size = 6'd1; cfg_rdy = 1'b1; cfg_stall = 1'b0; cfg_valid = 1'b1;
    #1;
    total_cnt++; if (cfg_ready !== 1'b0) $display("FAIL lr_cfg_ready got=%b exp=0", cfg_ready); else pass_cnt++;
    tick();
    link_reset = 1'b0; cfg_valid = 1'b0; cfg_ep = 4'd3; addr = 5'd2;
    #1;
    total_cnt++; if (has_data !== '0) $display("FAIL lr_rdy got=%b exp=0", has_data); else pass_cnt++;
    total_cnt++; if (sent !== '0) $display("FAIL lr_sent got=%b exp=0", sent); else pass_cnt++;
    total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL lr_unbusy got=%b exp=1", cfg_ready); else pass_cnt++;
    total_cnt++; if (stall_o !== 11'b1) $display("FAIL lr_stall_kept got=%b exp=%b", stall_o, 11'b1); else pass_cnt++;
    total_cnt++; if (raddr !== {5'd9, 5'd2}) $display("FAIL lr_buf_kept got=%h exp=%h", raddr, {5'd9, 5'd2}); else pass_cnt++;
    addr = 5'd15;
    #1;
    total_cnt++; if (done[3] !== 1'b0) $display("FAIL lr_size_kept15 got=%b exp=0", done[3]); else pass_cnt++;
    addr = 5'd16;
    #1;
    total_cnt++; if (done[3] !== 1'b1) $display("FAIL lr_size_kept16 got=%b exp=1", done[3]); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    cfg_write(5, 4, 4, 1'b1, 1'b1);
    cur = 4'd5; acked = 1'b1;
    tick();
    acked = 1'b0; cfg_ep = 4'd5;
    total_cnt++; if (pkt_sent !== 1'b1 || sent !== 11'b100000) $display("FAIL ar_pre got=%b/%b exp=1/%b", pkt_sent, sent, 11'b100000); else pass_cnt++;
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (has_data !== '0) $display("FAIL ar_rdy got=%b exp=0", has_data); else pass_cnt++;
    total_cnt++; if (stall_o !== '0) $display("FAIL ar_stall got=%b exp=0", stall_o); else pass_cnt++;
    total_cnt++; if (sent !== '0) $display("FAIL ar_sent got=%b exp=0", sent); else pass_cnt++;
    total_cnt++; if (pkt_sent !== 1'b0) $display("FAIL ar_pulse got=%b exp=0", pkt_sent); else pass_cnt++;
    total_cnt++; if (cfg_ready !== 1'b1) $display("FAIL ar_cfg_ready got=%b exp=1", cfg_ready); else pass_cnt++;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; link_reset = 1'b0; cfg_valid = 1'b0; cfg_ep = '0; cfg_buf = '0;
    cfg_size = '0; cfg_rdy = 1'b0; cfg_stall = 1'b0; sent_clr = '0; cur = '0;
    addr = '0; data_get = 1'b0; newpkt = 1'b0; acked = 1'b0; rollback = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    tick();
    rst_n = 1'b1;
    tick();
    test_config();
    test_packet();
    test_retry();
    test_zlp();
    test_clamp_stall();
    test_link_reset();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
